cjump_unit: RTL and testbench

CJUMP_UNIT -- requirements
Module: cjump

---
 rtl/cjump_unit_if.sv | 24 ++
 rtl/cjump_unit.sv | 62 ++++++
 tb/tb_cjump_unit.sv | 123 ++++++++++++
 3 files changed

// File: rtl/cjump_unit_if.sv
// cjump_unit_if -- request/result bundle for the jump-target unit.
//   master : drives jump_req, ShiftIn, PCNext; observes PCJout, jout_valid, misaligned
//   slave  : the unit itself (opposite directions)
interface cjump_unit_if #(
    parameter int PC_W  = 8,
    parameter int OUT_W = PC_W - 2
);
    logic             jump_req;
    logic [PC_W-1:0]  ShiftIn;
    logic [PC_W-1:0]  PCNext;
    logic [OUT_W-1:0] PCJout;
    logic             jout_valid;
    logic             misaligned;

    modport master (
        output jump_req, ShiftIn, PCNext,
        input  PCJout, jout_valid, misaligned
    );

    modport slave (
        input  jump_req, ShiftIn, PCNext,
        output PCJout, jout_valid, misaligned
    );
endinterface

// File: rtl/cjump_unit.sv
// cjump_unit -- registered J-type jump target generator.
//   Target (byte) = {PCNext[PC_W-1:PC_W-2], ShiftIn[PC_W-3:0]}; PCJout is its word
//   address. One-cycle latency; jout_valid pulses the cycle after each request.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : cjump_unit_if.slave (jump_req/ShiftIn/PCNext in, PCJout/jout_valid/misaligned out)
// Build option:
//   CJUMP_ALIGN_CHECK_EN -- when defined, misaligned registers ShiftIn[1:0] != 0;
//   otherwise misaligned is tied to 0.
// OUT_W must equal PC_W-2.
module cjump_unit #(
    parameter int PC_W  = 8,
    parameter int OUT_W = PC_W - 2
) (
    input  logic           clk,
    input  logic           reset,
    cjump_unit_if.slave    bus
);
    logic [OUT_W-1:0] pcj_q, pcj_d;
    logic             vld_q;

    // Region bits come from PCNext, in-region word offset from ShiftIn. Pure
    // concatenation: ShiftIn's top two bits are discarded, no carry into the region.
    assign pcj_d = {bus.PCNext[PC_W-1:PC_W-2], bus.ShiftIn[PC_W-3:2]};

    always_ff @(posedge clk) begin
        if (reset) begin
            pcj_q <= '0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= bus.jump_req;
            if (bus.jump_req)
                pcj_q <= pcj_d;
        end
    end

`ifdef CJUMP_ALIGN_CHECK_EN
    logic mis_q;

    always_ff @(posedge clk) begin
        if (reset)
            mis_q <= 1'b0;
        else if (bus.jump_req)
            mis_q <= |bus.ShiftIn[1:0];
    end

    assign bus.misaligned = mis_q;

    logic unused_bits;
    assign unused_bits = &{1'b0, bus.ShiftIn[PC_W-1:PC_W-2], bus.PCNext[PC_W-3:0]};
`else
    assign bus.misaligned = 1'b0;

    logic unused_bits;
    assign unused_bits = &{1'b0, bus.ShiftIn[PC_W-1:PC_W-2], bus.ShiftIn[1:0],
                           bus.PCNext[PC_W-3:0]};
`endif

    assign bus.PCJout     = pcj_q;
    assign bus.jout_valid = vld_q;
endmodule

// File: tb/tb_cjump_unit.sv
// tb_cjump_unit -- directed literal checks plus randomized traffic against a
// behavioural model of the jump-target unit.
module tb_cjump_unit;
    localparam int PC_W  = 8;
    localparam int OUT_W = 6;
`ifdef CJUMP_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cjump_unit_if #(.PC_W(PC_W), .OUT_W(OUT_W)) bus ();

    cjump_unit #(.PC_W(PC_W), .OUT_W(OUT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Model state: what the outputs must show after each edge.
    int m_pcj = 0;
    int m_vld = 0;
    int m_mis = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: byte target = region from PCNext (top two bits) plus
    // low byte offset of ShiftIn; word address is byte target / 4.
    always @(posedge clk) begin
        if (reset) begin
            m_pcj = 0; m_vld = 0; m_mis = 0;
        end else begin
            m_vld = bus.jump_req ? 1 : 0;
            if (bus.jump_req) begin
                m_pcj = ((int'(bus.PCNext) & 'hC0) + (int'(bus.ShiftIn) & 'h3F)) / 4;
                m_mis = (ALIGN && (int'(bus.ShiftIn) % 4 != 0)) ? 1 : 0;
            end
        end
    end

    // Compare every cycle once the unit has seen a reset.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_pcj", int'(bus.PCJout), m_pcj);
            check("cyc_vld", int'(bus.jout_valid), m_vld);
            check("cyc_mis", int'(bus.misaligned), m_mis);
        end
    end

    task automatic drive(input logic r, input logic j, input logic [7:0] s, input logic [7:0] p);
        @(negedge clk);
        reset = r; bus.jump_req = j; bus.ShiftIn = s; bus.PCNext = p;
    endtask

    task automatic edge_chk(input string name, input int pcj, input int vld, input int mis);
        @(posedge clk);
        #1;
        check({name, "_pcj"}, int'(bus.PCJout), pcj);
        check({name, "_vld"}, int'(bus.jout_valid), vld);
        check({name, "_mis"}, int'(bus.misaligned), mis);
    endtask

    initial begin
        reset = 1'b1; bus.jump_req = 1'b0; bus.ShiftIn = '0; bus.PCNext = '0;

        // Reset with inputs at zero.
        drive(1, 0, 8'h00, 8'h00);
        edge_chk("reset", 0, 0, 0);
        chk_en = 1'b1;

        // Misaligned offset still yields a target; only the flag differs.
        drive(0, 1, 8'h02, 8'h04);
        edge_chk("misal", 'h00, 1, ALIGN ? 1 : 0);

        // Top region, byte target 0xFC, then hold with no request.
        drive(0, 1, 8'h3C, 8'hC4);
        edge_chk("top", 'h3F, 1, 0);
        drive(0, 0, 8'hA5, 8'h5A);
        edge_chk("hold", 'h3F, 0, 0);

        // Back-to-back requests; ShiftIn top bits ignored on the second.
        drive(0, 1, 8'h10, 8'h40);
        edge_chk("b2b0", 'h14, 1, 0);
        drive(0, 1, 8'hF8, 8'h84);
        edge_chk("b2b1", 'h2E, 1, 0);
        drive(0, 0, 8'h00, 8'h00);
        edge_chk("b2b_end", 'h2E, 0, 0);

        // Reset wins over a simultaneous request and kills a pending pulse.
        drive(0, 1, 8'h3C, 8'hC4);
        edge_chk("pre_rst", 'h3F, 1, 0);
        drive(1, 1, 8'h20, 8'h80);
        edge_chk("rst_req", 0, 0, 0);
        drive(0, 0, 8'h20, 8'h80);
        edge_chk("rst_after", 0, 0, 0);

        // Randomized traffic, checked by the per-cycle comparator.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 24) == 0), $urandom_range(0, 1) == 1,
                  8'($urandom), 8'($urandom));
        end
        drive(0, 0, 8'h00, 8'h00);
        @(negedge clk);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
